// File: rtl/alu_64.sv
// Registered integer ALU for the Y86-64 execute stage: AND/XOR/ADD/SUB with
// result, carry-out and ZF/SF/OF latched one clock after a valid request.

module alu_64_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module alu_64 #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] P,
    input  logic [WIDTH-1:0] Q,
    input  logic [1:0]       select,
    output logic [WIDTH-1:0] Z,
    output logic             carryout,
    output logic             zf,
    output logic             sf,
    output logic             of,
    output logic             out_valid
);

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_XOR = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } op_e;

    op_e              op;
    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic [WIDTH:0]   carry;

    logic [WIDTH-1:0] z_q, z_d;
    logic             co_q, co_d;
    logic             zf_q, zf_d;
    logic             sf_q, sf_d;
    logic             of_q, of_d;
    logic             vld_q;

    assign op     = op_e'(select);
    assign is_sub = (op == OP_SUB);

    // SUB shares the adder: P + ~Q + 1
    assign b_eff    = is_sub ? ~Q : Q;
    assign carry[0] = is_sub;

    for (genvar i = 0; i < WIDTH; i++) begin : g_rca
        alu_64_fa u_fa (
            .a_i (P[i]),
            .b_i (b_eff[i]),
            .c_i (carry[i]),
            .s_o (sum[i]),
            .c_o (carry[i+1])
        );
    end

    always_comb begin
        z_d  = '0;
        co_d = 1'b0;
        of_d = 1'b0;
        unique case (op)
            OP_AND: z_d = P & Q;
            OP_XOR: z_d = P ^ Q;
            OP_ADD: begin
                z_d  = sum;
                co_d = carry[WIDTH];
                of_d = (P[WIDTH-1] == Q[WIDTH-1]) && (sum[WIDTH-1] != P[WIDTH-1]);
            end
            OP_SUB: begin
                z_d  = sum;
                co_d = carry[WIDTH];
                of_d = (P[WIDTH-1] != Q[WIDTH-1]) && (sum[WIDTH-1] != P[WIDTH-1]);
            end
            default: z_d = '0;
        endcase
        zf_d = (z_d == '0);
        sf_d = z_d[WIDTH-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q   <= '0;
            co_q  <= 1'b0;
            zf_q  <= 1'b0;
            sf_q  <= 1'b0;
            of_q  <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= in_valid;
            if (in_valid) begin
                z_q  <= z_d;
                co_q <= co_d;
                zf_q <= zf_d;
                sf_q <= sf_d;
                of_q <= of_d;
            end
        end
    end

    assign Z         = z_q;
    assign carryout  = co_q;
    assign zf        = zf_q;
    assign sf        = sf_q;
    assign of        = of_q;
    assign out_valid = vld_q;

endmodule

// File: tb/tb_alu_64.sv
// Directed-vector bench for alu_64: hand-computed results and flags per request.

module tb_alu_64;

    localparam int unsigned WIDTH = 64;
    localparam logic [1:0] S_AND = 2'b00;
    localparam logic [1:0] S_XOR = 2'b01;
    localparam logic [1:0] S_ADD = 2'b10;
    localparam logic [1:0] S_SUB = 2'b11;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] P;
    logic [WIDTH-1:0] Q;
    logic [1:0]       select;
    logic [WIDTH-1:0] Z;
    logic             carryout;
    logic             zf;
    logic             sf;
    logic             of;
    logic             out_valid;

    int unsigned n_tests;
    int unsigned n_fail;

    alu_64 #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .P         (P),
        .Q         (Q),
        .select    (select),
        .Z         (Z),
        .carryout  (carryout),
        .zf        (zf),
        .sf        (sf),
        .of        (of),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [63:0] ez, input logic eco,
                             input logic ezf, input logic esf, input logic eof, input logic ev);
        check({tag, ".Z"},        Z,         ez);
        check({tag, ".carryout"}, carryout,  eco);
        check({tag, ".zf"},       zf,        ezf);
        check({tag, ".sf"},       sf,        esf);
        check({tag, ".of"},       of,        eof);
        check({tag, ".valid"},    out_valid, ev);
    endtask

    task automatic do_op(input logic [1:0] sel, input logic [63:0] p, input logic [63:0] q);
        @(negedge clk);
        in_valid = 1'b1;
        select   = sel;
        P        = p;
        Q        = q;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        select   = S_ADD;
        P        = 64'd5;
        Q        = 64'd7;

        // 1: reset held with requests present
        repeat (3) @(posedge clk);
        #1;
        check_all("reset", 64'd0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;

        // 2: simple add, then hold
        do_op(S_ADD, 64'd5, 64'd7);
        check_all("add5_7", 64'd12, 0, 0, 0, 0, 1);
        idle_cycle();
        check("hold.valid", out_valid, 1'b0);
        check("hold.Z", Z, 64'd12);
        check("hold.zf", zf, 1'b0);

        // 3: add overflow and wrap
        do_op(S_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        check_all("add_ovf", 64'h8000_0000_0000_0000, 0, 0, 1, 1, 1);
        do_op(S_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        check_all("add_wrap", 64'd0, 1, 1, 0, 0, 1);

        // 4: subtraction cases
        do_op(S_SUB, 64'd3, 64'd3);
        check_all("sub_eq", 64'd0, 1, 1, 0, 0, 1);
        do_op(S_SUB, 64'd0, 64'd1);
        check_all("sub_borrow", 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1, 0, 1);
        do_op(S_SUB, 64'h8000_0000_0000_0000, 64'd1);
        check_all("sub_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 1, 0, 0, 1, 1);

        // 5: logic ops
        do_op(S_AND, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00);
        check_all("and", 64'hF000_F000_F000_F000, 0, 0, 1, 0, 1);
        do_op(S_XOR, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0);
        check_all("xor_eq", 64'd0, 0, 1, 0, 0, 1);

        // 6: back-to-back with async reset during the third request
        do_op(S_ADD, 64'd1, 64'd2);
        check_all("b2b_add", 64'd3, 0, 0, 0, 0, 1);
        do_op(S_SUB, 64'd10, 64'd4);
        check_all("b2b_sub", 64'd6, 1, 0, 0, 0, 1);
        select = S_AND;
        P      = 64'hFFFF_0000_FFFF_0000;
        Q      = 64'hFFFF_FFFF_0000_0000;
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 64'd0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check_all("in_rst", 64'd0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        select = S_XOR;
        P      = 64'h0000_0000_0000_00FF;
        Q      = 64'h0000_0000_0000_000F;
        #2;
        check_all("post_rel", 64'd0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check_all("b2b_xor", 64'h0000_0000_0000_00F0, 0, 0, 0, 0, 1);
        idle_cycle();
        check("end.valid", out_valid, 1'b0);
        check("end.Z", Z, 64'h0000_0000_0000_00F0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
